// File: rtl/mult_pkg.sv
// Shared width and state encoding for the iterative shift-and-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 64;

    typedef enum logic [1:0] {
        M_IDLE,
        M_BUSY,
        M_DONE
    } mult_state_t;

endpackage

// File: rtl/mult_pp_gen.sv
// Partial-product generator: multiplicand gated bit-by-bit with the current multiplier bit.
module mult_pp_gen
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic             mbit,
    output logic [WIDTH-1:0] pp
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_and
            assign pp[i] = mcand[i] & mbit;
        end
    endgenerate

endmodule

// File: rtl/mult_seq_64.sv
// Iterative unsigned multiplier: one shift-and-add step per cycle, fixed WIDTH-step latency,
// valid/ready on both sides. Product registers hold the last result until the next one lands.
module mult_seq_64
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] STEPS = CW'(WIDTH);

    mult_state_t state, state_next;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum_c;
    logic [2*WIDTH-1:0] acc_step;

    logic load;
    logic step;
    logic finish;

    mult_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .mcand (mcand),
        .mbit  (acc[0]),
        .pp    (pp)
    );

    // The carry out of the upper-half add becomes the new MSB, so all-ones operands fit.
    assign sum_c    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, pp};
    assign acc_step = {sum_c, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= M_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            M_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    load       = 1'b1;
                    state_next = M_BUSY;
                end
            end
            M_BUSY: begin
                if (flush) begin
                    state_next = M_IDLE;
                end else if (count == STEPS) begin
                    finish     = 1'b1;
                    state_next = M_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            M_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_next = M_IDLE;
                end
            end
            default: state_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            count   <= '0;
            prod_lo <= '0;
            prod_hi <= '0;
        end else begin
            if (load) begin
                mcand <= A;
                acc   <= {{WIDTH{1'b0}}, B};
                count <= '0;
            end
            if (step) begin
                acc   <= acc_step;
                count <= count + CW'(1);
            end
            if (finish) begin
                prod_lo <= acc[WIDTH-1:0];
                prod_hi <= acc[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_64.sv
// Bench for mult_seq_64: directed scenarios plus random operands against a plain-arithmetic model.
module tb_mult_seq_64;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [63:0] a, b;
    logic        in_ready, out_valid;
    logic [63:0] prod_lo, prod_hi;

    int checks   = 0;
    int failures = 0;

    mult_seq_64 dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod_lo   (prod_lo),
        .prod_hi   (prod_hi)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] wx, wy;
        wx = {64'd0, x};
        wy = {64'd0, y};
        return wx * wy;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; caller guarantees the block is idle.
    task automatic issue(input logic [63:0] x, input logic [63:0] y);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid is seen; -1 if it never appears.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod_lo !== 64'd0 || prod_hi !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b hi=%h lo=%h, required 1 0 0 0",
                     in_ready, out_valid, prod_hi, prod_lo);
        end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        issue(64'd3, 64'd5);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_ready: in_ready=%b, required 0", in_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== 65) begin
            failures++;
            $display("FAIL basic_latency: got %0d, required 65", lat);
        end
        checks++;
        if (prod_lo !== 64'd15 || prod_hi !== 64'd0) begin
            failures++;
            $display("FAIL basic_product: hi=%h lo=%h, required 0 / f", prod_hi, prod_lo);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        issue('1, '1);
        wait_done(lat);
        checks++;
        if (lat !== 65 || prod_hi !== 64'hFFFF_FFFF_FFFF_FFFE || prod_lo !== 64'h1) begin
            failures++;
            $display("FAIL all_ones: lat=%0d hi=%h lo=%h, required 65 fffffffffffffffe 1", lat, prod_hi, prod_lo);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        issue(64'h1_0000_0000, 64'h1_0000_0000);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = 64'd99;
            b = 64'd99;
            tick();
            if (out_valid !== 1'b1 || prod_hi !== 64'd1 || prod_lo !== 64'd0 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== 65 || bad !== 0) begin
            failures++;
            $display("FAIL backpressure_hold: lat=%0d unstable_cycles=%0d, required 65 0", lat, bad);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod_hi !== 64'd1 || prod_lo !== 64'd0) begin
            failures++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b hi=%h lo=%h, required 1 0 1 0",
                     in_ready, out_valid, prod_hi, prod_lo);
        end
    endtask

    task automatic test_flush();
        int lat;
        int rose = 0;
        issue(64'd7, 64'd9);
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod_hi !== 64'd1 || prod_lo !== 64'd0) begin
            failures++;
            $display("FAIL flush_busy: in_ready=%b out_valid=%b hi=%h lo=%h, required 1 0 1 0",
                     in_ready, out_valid, prod_hi, prod_lo);
        end
        repeat (80) begin
            tick();
            if (out_valid !== 1'b0) rose++;
        end
        checks++;
        if (rose !== 0) begin
            failures++;
            $display("FAIL flush_no_result: out_valid high for %0d cycles, required 0", rose);
        end
        in_valid = 1'b1;
        flush    = 1'b1;
        a        = 64'd5;
        b        = 64'd5;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_blocks_accept: in_ready=%b, required 1", in_ready);
        end
        issue(64'd2, 64'd4);
        wait_done(lat);
        checks++;
        if (lat !== 65 || prod_lo !== 64'd8 || prod_hi !== 64'd0) begin
            failures++;
            $display("FAIL flush_next_op: lat=%0d hi=%h lo=%h, required 65 0 8", lat, prod_hi, prod_lo);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        int bad = 0;
        issue(64'd6, 64'd7);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = 64'd1;
            b = 64'd1;
            tick();
            if (in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bad !== 0 || in_ready !== 1'b1 || out_valid !== 1'b0 || prod_lo !== 64'd0 || prod_hi !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_busy: busy_ready=%0d in_ready=%b out_valid=%b hi=%h lo=%h, required 0 1 0 0 0",
                     bad, in_ready, out_valid, prod_hi, prod_lo);
        end
        out_ready = 1'b0;
        issue(64'd6, 64'd7);
        in_valid = 1'b1;
        a = 64'd1;
        b = 64'd1;
        wait_done(lat);
        tick();
        checks++;
        if (lat !== 65 || out_valid !== 1'b1 || prod_lo !== 64'd42 || prod_hi !== 64'd0) begin
            failures++;
            $display("FAIL ignore_in_valid: lat=%0d out_valid=%b hi=%h lo=%h, required 65 1 0 2a",
                     lat, out_valid, prod_hi, prod_lo);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic rdy_idle, rdy_busy;
        out_ready = 1'b1;
        a        = 64'd10;
        b        = 64'd10;
        in_valid = 1'b1;
        tick();
        a = 64'd0;
        b = 64'd123;
        wait_done(lat1);
        checks++;
        if (lat1 !== 65 || prod_lo !== 64'd100 || prod_hi !== 64'd0) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d hi=%h lo=%h, required 65 0 64", lat1, prod_hi, prod_lo);
        end
        tick();
        rdy_idle = in_ready;
        tick();
        rdy_busy = in_ready;
        in_valid = 1'b0;
        wait_done(lat2);
        checks++;
        if (rdy_idle !== 1'b1 || rdy_busy !== 1'b0 || lat2 !== 65 || prod_lo !== 64'd0 || prod_hi !== 64'd0) begin
            failures++;
            $display("FAIL b2b_second: idle_ready=%b busy_ready=%b lat=%0d hi=%h lo=%h, required 1 0 65 0 0",
                     rdy_idle, rdy_busy, lat2, prod_hi, prod_lo);
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        int bad = 0;
        logic [63:0]  x, y;
        logic [127:0] exp_p;
        for (int n = 0; n < 24; n++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            if (n % 6 == 1) x[63] = 1'b1;
            if (n % 6 == 2) y = 64'd1;
            exp_p     = model(x, y);
            out_ready = 1'b0;
            issue(x, y);
            wait_done(lat);
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (lat !== 65 || out_valid !== 1'b1 || {prod_hi, prod_lo} !== exp_p) begin
                failures++;
                bad++;
                $display("FAIL random_op%0d: a=%h b=%h lat=%0d got %h, required %h",
                         n, x, y, lat, {prod_hi, prod_lo}, exp_p);
            end
            out_ready = 1'b1;
            tick();
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL random_end_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #1;
        test_reset();
        test_basic();
        test_all_ones();
        test_backpressure();
        test_flush();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
